// File: rtl/bus_master_ctrl.sv
// 68000-bus initiator: arbitrates for the shared CPU bus with BR/BG/BGACK, runs one
// word/byte read or write cycle per accepted request, then hands the bus back.
module bus_master_ctrl #(
  parameter int unsigned DTACK_TIMEOUT = 255,
  parameter int unsigned SETUP_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [22:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        br_n,
  input  logic        bg_n,
  output logic        bgack_n,
  input  logic        as_in_n,
  output logic        as_n_out,
  output logic        rw_out,
  output logic        uds_n_out,
  output logic        lds_n_out,
  output logic        ctl_oe,
  output logic [22:0] addr_out,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic [15:0] data_in,
  input  logic        dtack_n,
  input  logic        berr_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BE_ZERO,
    S_REQ_BUS,
    S_OWN,
    S_ASSERT,
    S_WAIT_ACK,
    S_RELEASE,
    S_HANDOFF
  } state_e;

  localparam logic [15:0] TMO_LAST   = 16'(DTACK_TIMEOUT - 1);
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;

  logic [1:0]  bgSync_q, asSync_q, dtackSync_q, berrSync_q;
  logic        bgS, asS, dtackS, berrS;
  logic        handoffDone;
  logic        busOwned, strobesOn;

  // All CPU-side handshake lines are asynchronous; reset them to the idle (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bgSync_q    <= 2'b11;
      asSync_q    <= 2'b11;
      dtackSync_q <= 2'b11;
      berrSync_q  <= 2'b11;
    end else begin
      bgSync_q    <= {bgSync_q[0], bg_n};
      asSync_q    <= {asSync_q[0], as_in_n};
      dtackSync_q <= {dtackSync_q[0], dtack_n};
      berrSync_q  <= {berrSync_q[0], berr_n};
    end
  end

  assign bgS    = bgSync_q[1];
  assign asS    = asSync_q[1];
  assign dtackS = dtackSync_q[1];
  assign berrS  = berrSync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 16'hFFFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // The slave must drop DTACK/BERR before the bus is handed back, but never wait forever.
  assign handoffDone = (dtackS && berrS) || (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          we_d    = req_we;
          err_d   = (req_be == 2'b00);
          state_d = (req_be == 2'b00) ? S_BE_ZERO : S_REQ_BUS;
        end
      end
      S_BE_ZERO: state_d = S_IDLE;
      S_REQ_BUS: begin
        if (!bgS && asS && dtackS) begin
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_ASSERT;
        end
      end
      S_ASSERT: state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        // BERR takes priority over a simultaneous DTACK.
        if (!berrS) begin
          err_d   = 1'b1;
          state_d = S_RELEASE;
          if (!we_q) begin
            rdata_d = 16'hFFFF;
          end
        end else if (!dtackS) begin
          state_d = S_RELEASE;
          if (!we_q) begin
            rdata_d = data_in;
          end
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          rdata_d = 16'hFFFF;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_HANDOFF;
      S_HANDOFF: begin
        if (handoffDone) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    br_n      = 1'b1;
    bgack_n   = 1'b1;
    as_n_out  = 1'b1;
    uds_n_out = 1'b1;
    lds_n_out = 1'b1;
    rw_out    = 1'b1;
    ctl_oe    = 1'b0;
    data_oe   = 1'b0;
    busOwned  = 1'b0;
    strobesOn = 1'b0;

    case (state_q)
      S_IDLE:     req_ready = 1'b1;
      S_BE_ZERO:  rsp_valid = 1'b1;
      S_REQ_BUS:  br_n = 1'b0;
      S_OWN:      busOwned = 1'b1;
      S_ASSERT: begin
        busOwned  = 1'b1;
        as_n_out  = 1'b0;
        strobesOn = ~we_q;
      end
      S_WAIT_ACK: begin
        busOwned  = 1'b1;
        as_n_out  = 1'b0;
        strobesOn = 1'b1;
      end
      S_RELEASE:  busOwned = 1'b1;
      S_HANDOFF: begin
        if (handoffDone) begin
          rsp_valid = 1'b1;
        end else begin
          busOwned = 1'b1;
        end
      end
      default: ;
    endcase

    if (busOwned) begin
      bgack_n = 1'b0;
      ctl_oe  = 1'b1;
      data_oe = we_q;
      rw_out  = ~we_q;
    end
    if (strobesOn) begin
      uds_n_out = ~be_q[1];
      lds_n_out = ~be_q[0];
    end
  end

  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rdata_q;
  assign addr_out  = addr_q;
  assign data_out  = wdata_q;

endmodule
